// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package sub_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for a given operand width (CW = $clog2(WIDTH)).
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/fs_cell.sv
// One-bit combinational full subtractor: diff = x - y - bi, borrow out on bo.
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);

    assign diff = x ^ y ^ bi;
    assign bo   = (~x & y) | (~x & bi) | (y & bi);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one fs_cell plus a registered borrow.
//  state | meaning
//  IDLE  | waiting for start, results held
//  RUN   | one bit processed per clock, cnt counts bits done
//  DONE  | one-cycle done pulse, may accept a new start
module serial_sub
    import sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-2:0] sr_q, sr_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             x_bit;
    logic             nb_bit;
    logic [WIDTH-1:0] sr_next;

    fs_cell u_fs (
        .x    (sa_q[0]),
        .y    (sb_q[0]),
        .bi   (br_q),
        .diff (x_bit),
        .bo   (nb_bit)
    );

    // Only WIDTH-1 partial bits need storing; the last bit goes straight to d.
    assign sr_next = {x_bit, sr_q};

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sr_d  = sr_next[WIDTH-1:1];
                br_d  = nb_bit;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    d_d     = sr_next;
                    bout_d  = nb_bit;
                    ovf_d   = br_q ^ nb_bit;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule
